// File: rtl/ped_signal_ctrl_if.sv
// Pedestrian controller bus: vehicle state and push-button in, lamps and status out.
//   state_in    [3:0] one-hot vehicle state (OFF/RED/YELLOW/GREEN)
//   ped_req           push-button
//   walk, dont_walk   lamp drives
//   req_pending       latched request waiting for service
//   countdown   [5:0] clearance cycles remaining
//   fault             sticky illegal-state flag
// master drives the inputs (stimulus/upstream); slave is the controller.
interface ped_signal_ctrl_if;
    logic [3:0] state_in;
    logic       ped_req;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [5:0] countdown;
    logic       fault;

    modport master (
        output state_in, ped_req,
        input  walk, dont_walk, req_pending, countdown, fault
    );

    modport slave (
        input  state_in, ped_req,
        output walk, dont_walk, req_pending, countdown, fault
    );
endinterface

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller downstream of the vehicle semaphore.
// Grants at most one WALK per vehicle RED phase when a request is pending,
// follows it with a flashing clearance, and aborts on any departure from RED.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ped_signal_ctrl_if.slave (state_in, ped_req in; walk, dont_walk,
//          req_pending, countdown, fault out; all outputs registered)
// Build option: PED_REQ_SYNC_EN adds a 2-flop synchronizer on ped_req
// (request-to-req_pending latency 3 edges instead of 1).
module ped_signal_ctrl #(
    parameter int unsigned WALK_CYC  = 8,
    parameter int unsigned CLEAR_CYC = 6,
    parameter int unsigned FLASH_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    ped_signal_ctrl_if.slave bus
);
    localparam int unsigned CDW = 6;
    localparam int unsigned WCW = (WALK_CYC > 1) ? $clog2(WALK_CYC) : 1;
    localparam int unsigned FCW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [3:0] VS_OFF    = 4'b0001;
    localparam logic [3:0] VS_RED    = 4'b0010;
    localparam logic [3:0] VS_YELLOW = 4'b0100;
    localparam logic [3:0] VS_GREEN  = 4'b1000;

    typedef enum logic [1:0] {ST_DW, ST_WALK, ST_CLEAR, ST_DARK} state_e;

    state_e         state_q, state_d;
    logic           walk_q, walk_d;
    logic           dont_walk_q, dont_walk_d;
    logic           req_q, req_d;
    logic           fault_q, fault_d;
    logic           served_q, served_d;
    logic [CDW-1:0] cd_q, cd_d;
    logic [WCW-1:0] walk_cnt_q, walk_cnt_d;
    logic [FCW-1:0] flash_cnt_q, flash_cnt_d;
    logic           req_s;
    logic           is_red, is_off, legal, enter_walk;

`ifdef PED_REQ_SYNC_EN
    // Two-flop synchronizer for the asynchronous push-button
    logic sync1_q, sync2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.ped_req;
            sync2_q <= sync1_q;
        end
    end
    assign req_s = sync2_q;
`else
    assign req_s = bus.ped_req;
`endif

    assign is_red = (bus.state_in == VS_RED);
    assign is_off = (bus.state_in == VS_OFF);
    assign legal  = is_off || is_red || (bus.state_in == VS_YELLOW) ||
                    (bus.state_in == VS_GREEN);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DW;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            req_q       <= 1'b0;
            fault_q     <= 1'b0;
            served_q    <= 1'b0;
            cd_q        <= '0;
            walk_cnt_q  <= '0;
            flash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            req_q       <= req_d;
            fault_q     <= fault_d;
            served_q    <= served_d;
            cd_q        <= cd_d;
            walk_cnt_q  <= walk_cnt_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        walk_d      = walk_q;
        dont_walk_d = dont_walk_q;
        req_d       = req_q | req_s;
        fault_d     = fault_q;
        served_d    = served_q;
        cd_d        = cd_q;
        walk_cnt_d  = walk_cnt_q;
        flash_cnt_d = flash_cnt_q;
        enter_walk  = 1'b0;

        // Leaving RED re-arms the one-walk-per-RED-phase guard
        if (!is_red) begin
            served_d = 1'b0;
        end

        if (!legal) begin
            state_d = ST_DW;
            fault_d = 1'b1;
        end else if (is_off) begin
            state_d = ST_DARK;
        end else if ((state_q == ST_WALK || state_q == ST_CLEAR) && !is_red) begin
            state_d = ST_DW;
        end else if ((state_q == ST_DW || state_q == ST_DARK) && is_red &&
                     req_q && !served_q && !fault_q) begin
            state_d    = ST_WALK;
            enter_walk = 1'b1;
        end else if (state_q == ST_DARK) begin
            state_d = ST_DW;
        end else if (state_q == ST_WALK && walk_cnt_q == WCW'(WALK_CYC - 1)) begin
            state_d = ST_CLEAR;
        end else if (state_q == ST_CLEAR && cd_q == CDW'(1)) begin
            state_d = ST_DW;
        end

        // Entry into WALK consumes the request, even one arriving on this edge
        if (enter_walk) begin
            req_d    = 1'b0;
            served_d = 1'b1;
        end

        case (state_d)
            ST_DW: begin
                walk_d      = 1'b0;
                dont_walk_d = 1'b1;
                cd_d        = '0;
            end
            ST_WALK: begin
                walk_d      = 1'b1;
                dont_walk_d = 1'b0;
                cd_d        = '0;
                walk_cnt_d  = enter_walk ? '0 : walk_cnt_q + WCW'(1);
            end
            ST_CLEAR: begin
                walk_d = 1'b0;
                if (state_q != ST_CLEAR) begin
                    cd_d        = CDW'(CLEAR_CYC);
                    dont_walk_d = 1'b1;
                    flash_cnt_d = '0;
                end else begin
                    cd_d = cd_q - CDW'(1);
                    if (flash_cnt_q == FCW'(FLASH_DIV - 1)) begin
                        dont_walk_d = ~dont_walk_q;
                        flash_cnt_d = '0;
                    end else begin
                        flash_cnt_d = flash_cnt_q + FCW'(1);
                    end
                end
            end
            ST_DARK: begin
                walk_d      = 1'b0;
                dont_walk_d = 1'b0;
                cd_d        = '0;
            end
            default: begin
                walk_d      = 1'b0;
                dont_walk_d = 1'b1;
                cd_d        = '0;
            end
        endcase
    end

    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dont_walk_q;
    assign bus.req_pending = req_q;
    assign bus.countdown   = cd_q;
    assign bus.fault       = fault_q;
endmodule
